// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the shared single-ported program/data RAM.
// Each transaction is arbitrate (IDLE) -> RAM access (ACCESS) -> done pulse (RESP).
module mem_arbiter #(
    parameter int unsigned RAM_WORDS    = 128,
    parameter logic [15:0] FILL         = 16'hf345,
    parameter int unsigned PRIO_MODE    = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [11:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [11:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic [15:0] a_rdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic [15:0] b_rdata,
    output logic [6:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    localparam int unsigned AW  = 12;
    localparam int unsigned MAW = 7;
    localparam int unsigned CW  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_owner;      // 0 = port A, 1 = port B
    logic          r_last;       // winner of the previous arbitration
    logic          r_we;
    logic          r_in_range;
    logic [CW-1:0] r_starve;
    logic [15:0]   r_a_rdata;
    logic [15:0]   r_b_rdata;

    logic          w_pick_b;
    logic          w_we;
    logic          w_in_range;
    logic          w_resp_rd;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_wdata;
    logic [15:0]   w_rd_word;

    // Winner selection and the winner's transaction payload
    always_comb begin
        w_pick_b = b_req && !a_req;
        if (a_req && b_req) begin
            if (PRIO_MODE == 0) begin
                w_pick_b = !r_last;
            end else begin
                w_pick_b = (r_starve >= CW'(STARVE_LIMIT));
            end
        end
        w_we       = w_pick_b ? b_we    : a_we;
        w_addr     = w_pick_b ? b_addr  : a_addr;
        w_wdata    = w_pick_b ? b_wdata : a_wdata;
        w_in_range = (w_addr < AW'(RAM_WORDS));
        w_rd_word  = r_in_range ? mem_rdata : FILL;
        w_resp_rd  = (r_state == RESP) && !r_we;
    end

    // RAM data arrives in the RESP cycle, so it is forwarded there and held afterwards
    assign a_rdata = (w_resp_rd && !r_owner) ? w_rd_word : r_a_rdata;
    assign b_rdata = (w_resp_rd &&  r_owner) ? w_rd_word : r_b_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            r_starve   <= '0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (!b_req || w_pick_b) begin
                        r_starve <= '0;
                    end else if (r_starve != {CW{1'b1}}) begin
                        r_starve <= r_starve + CW'(1);
                    end
                    if (a_req || b_req) begin
                        r_owner    <= w_pick_b;
                        r_last     <= w_pick_b;
                        r_we       <= w_we;
                        r_in_range <= w_in_range;
                        a_gnt      <= !w_pick_b;
                        b_gnt      <= w_pick_b;
                        mem_addr   <= w_addr[MAW-1:0];
                        mem_we     <= w_we && w_in_range;
                        mem_wdata  <= w_wdata;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    a_done  <= !r_owner;
                    b_done  <= r_owner;
                    r_state <= RESP;
                end
                RESP: begin
                    if (!r_we) begin
                        if (r_owner) begin
                            r_b_rdata <= w_rd_word;
                        end else begin
                            r_a_rdata <= w_rd_word;
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 in round-robin mode, instance 1 in A-priority mode.
// Directed cases followed by randomized masters checked against a reference memory and arbitration model.
module tb_mem_arbiter;
    localparam logic [15:0] FILL     = 16'hf345;
    localparam int unsigned STARVE   = 4;
    localparam int          RAND_CYC = 10000;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    logic [1:0]       a_req, b_req, a_we, b_we;
    logic [1:0][11:0] a_addr, b_addr;
    logic [1:0][15:0] a_wdata, b_wdata;
    logic [1:0]       a_gnt, b_gnt, a_done, b_done, mem_we;
    logic [1:0][15:0] a_rdata, b_rdata, mem_wdata;
    logic [1:0][6:0]  mem_addr;

    logic [15:0] ref_mem [2][128];
    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int ta, tb, ndone, losses, t_end;
    logic [15:0] brd;
    logic seen_we;
    bit bdone;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] ram [128];
        logic [15:0] rdq;
        logic        pa, pb, last_b, eb, ewe;
        logic [11:0] eaddr;
        int unsigned lost;

        mem_arbiter #(
            .RAM_WORDS(128), .FILL(FILL), .PRIO_MODE(g), .STARVE_LIMIT(STARVE)
        ) u_dut (
            .clk(clk), .rst(rst),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .a_gnt(a_gnt[g]), .a_done(a_done[g]), .a_rdata(a_rdata[g]),
            .b_gnt(b_gnt[g]), .b_done(b_done[g]), .b_rdata(b_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(rdq)
        );

        // Synchronous-read RAM; req values seen by the arbiter at each edge
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 128; i++) ram[i] <= 16'h122f + 16'(i);
            end else if (mem_we[g]) begin
                ram[mem_addr[g]] <= mem_wdata[g];
            end
            rdq <= ram[mem_addr[g]];
            pa  <= a_req[g];
            pb  <= b_req[g];
        end

        // Arbitration model: who should win each grant, and B's run of lost arbitrations
        always @(negedge clk) begin
            if (!mon_en) begin
                last_b = 1'b1;
                lost   = 0;
            end else begin
                if (a_gnt[g] || b_gnt[g]) begin
                    if (pa && pb) eb = (g == 0) ? !last_b : (lost >= STARVE);
                    else          eb = pb;
                    chk("two_gnt", 32'(a_gnt[g] & b_gnt[g]), 0);
                    chk("winner_is_b", 32'(b_gnt[g]), 32'(eb));
                    eaddr = eb ? b_addr[g] : a_addr[g];
                    ewe   = eb ? b_we[g] : a_we[g];
                    chk("mem_we", 32'(mem_we[g]), 32'(ewe && (eaddr < 12'd128)));
                    chk("mem_addr", 32'(mem_addr[g]), 32'(eaddr[6:0]));
                    if (eb || !pb)     lost = 0;
                    else if (lost < 15) lost = lost + 1;
                    last_b = eb;
                    chk("starve_bound", 32'(lost <= STARVE), 1);
                end else begin
                    chk("we_idle", 32'(mem_we[g]), 0);
                end
                chk("two_done", 32'(a_done[g] & b_done[g]), 0);
            end
        end
    end

    task automatic drive(input int m, input bit p, input logic req, input logic we,
                         input logic [11:0] addr, input logic [15:0] wd);
        if (p) begin
            b_req[m] = req; b_we[m] = we; b_addr[m] = addr; b_wdata[m] = wd;
        end else begin
            a_req[m] = req; a_we[m] = we; a_addr[m] = addr; a_wdata[m] = wd;
        end
    endtask

    function automatic logic get_done(input int m, input bit p);
        return p ? b_done[m] : a_done[m];
    endfunction

    function automatic logic [15:0] get_rdata(input int m, input bit p);
        return p ? b_rdata[m] : a_rdata[m];
    endfunction

    task automatic do_reset(input bit init);
        rst = 1'b1; ram_init = init;
        a_req = '0; b_req = '0; a_we = '0; b_we = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; ram_init = 1'b0;
        if (init) begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 128; i++) ref_mem[m][i] = 16'h122f + 16'(i);
        end
    endtask

    // Random master for one port: issue, wait (bounded) for done, check data against ref_mem
    task automatic master(input int m, input bit p, input int tlim);
        logic        we;
        logic [11:0] addr;
        logic [15:0] wd, exp_rd, prev;
        bit          got;
        prev = 16'h0;
        while (cyc < tlim) begin
            drive(m, p, 1'b0, 1'b0, 12'h0, 16'h0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("spurious_done", 32'(get_done(m, p)), 0);
            end
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(128, 4095))
                                               : 12'($urandom_range(0, 127));
            wd   = 16'($urandom);
            drive(m, p, 1'b1, we, addr, wd);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                got = get_done(m, p);
            end
            chk("done_timeout", 32'(got), 1);
            if (got) begin
                if (we) begin
                    if (addr < 12'd128) ref_mem[m][addr[6:0]] = wd;
                    chk("wr_rdata_hold", 32'(get_rdata(m, p)), 32'(prev));
                end else begin
                    exp_rd = (addr < 12'd128) ? ref_mem[m][addr[6:0]] : FILL;
                    chk("rd_data", 32'(get_rdata(m, p)), 32'(exp_rd));
                    prev = exp_rd;
                end
            end
        end
        drive(m, p, 1'b0, 1'b0, 12'h0, 16'h0);
    endtask

    initial begin
        do_reset(1'b1);
        for (int m = 0; m < 2; m++) begin
            chk("rst_ctl", 32'({a_gnt[m], b_gnt[m], a_done[m], b_done[m], mem_we[m]}), 0);
            chk("rst_rdata", {a_rdata[m], b_rdata[m]}, 0);
            chk("rst_mem", 32'({mem_addr[m], mem_wdata[m]}), 0);
        end

        // A reads RAM[5]
        drive(0, 0, 1'b1, 1'b0, 12'h005, 16'h0);
        @(negedge clk);
        chk("rd_c1_gnt", 32'({a_gnt[0], b_gnt[0], a_done[0]}), 32'b100);
        chk("rd_c1_maddr", 32'(mem_addr[0]), 5);
        @(negedge clk);
        chk("rd_c2_done", 32'({a_gnt[0], b_gnt[0], a_done[0], b_done[0]}), 32'b0010);
        chk("rd_c2_data", 32'(a_rdata[0]), 32'h1234);
        drive(0, 0, 1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clk);
        chk("rd_hold", 32'({a_done[0], a_rdata[0]}), 32'h1234);

        // Simultaneous requests in round-robin mode: A write, then B read of the same word
        do_reset(1'b0);
        drive(0, 0, 1'b1, 1'b1, 12'h010, 16'hBEEF);
        drive(0, 1, 1'b1, 1'b0, 12'h010, 16'h0);
        ta = -1; tb = -1; brd = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_done[0]) begin ta = k; drive(0, 0, 1'b0, 1'b0, 12'h0, 16'h0); end
            if (b_done[0]) begin tb = k; brd = b_rdata[0]; drive(0, 1, 1'b0, 1'b0, 12'h0, 16'h0); end
        end
        chk("tie_a_done_cyc", 32'(ta), 2);
        chk("tie_b_done_cyc", 32'(tb), 5);
        chk("tie_b_rdata", 32'(brd), 32'hBEEF);

        // Out-of-range read returns the filler; out-of-range write never strobes the RAM
        drive(0, 0, 1'b1, 1'b0, 12'h900, 16'h0);
        repeat (2) @(negedge clk);
        chk("oor_rd_done", 32'(a_done[0]), 1);
        chk("oor_rd_data", 32'(a_rdata[0]), 32'(FILL));
        drive(0, 0, 1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b1, 12'h1FF, 16'hAAAA);
        seen_we = 1'b0; ndone = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            seen_we = seen_we | mem_we[0];
            if (a_done[0]) begin ndone++; drive(0, 0, 1'b0, 1'b0, 12'h0, 16'h0); end
        end
        chk("oor_wr_we", 32'(seen_we), 0);
        chk("oor_wr_done", 32'(ndone), 1);
        chk("oor_wr_hold", 32'(a_rdata[0]), 32'(FILL));

        // Reset during ACCESS aborts the read; the re-issued request completes
        drive(0, 0, 1'b1, 1'b0, 12'h007, 16'h0);
        @(negedge clk);
        chk("abort_gnt", 32'(a_gnt[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctl", 32'({a_gnt[0], b_gnt[0], a_done[0], b_done[0], mem_we[0]}), 0);
        chk("abort_rdata", 32'(a_rdata[0]), 0);
        chk("abort_mem", 32'({mem_addr[0], mem_wdata[0]}), 0);
        ta = -1; brd = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (a_done[0]) begin ta = k; brd = a_rdata[0]; drive(0, 0, 1'b0, 1'b0, 12'h0, 16'h0); end
        end
        chk("reissue_done_cyc", 32'(ta), 2);
        chk("reissue_data", 32'(brd), 32'h1236);

        // A-priority mode: B loses exactly STARVE arbitrations, twice in a row
        do_reset(1'b0);
        drive(1, 0, 1'b1, 1'b0, 12'h001, 16'h0);
        drive(1, 1, 1'b1, 1'b0, 12'h002, 16'h0);
        for (int r = 0; r < 2; r++) begin
            losses = 0; bdone = 1'b0;
            for (int k = 0; k < 60 && !bdone; k++) begin
                @(negedge clk);
                if (a_gnt[1] && b_req[1]) losses++;
                if (b_gnt[1]) chk("starve_losses", 32'(losses), 32'(STARVE));
                if (b_done[1]) bdone = 1'b1;
            end
            chk("starve_b_done", 32'(bdone), 1);
            drive(1, 1, 1'b0, 1'b0, 12'h0, 16'h0);
            @(negedge clk);
            drive(1, 1, 1'b1, 1'b0, 12'h002, 16'h0);
        end

        // Randomized traffic on both instances
        do_reset(1'b1);
        mon_en = 1'b1;
        t_end  = cyc + RAND_CYC;
        fork
            master(0, 1'b0, t_end);
            master(0, 1'b1, t_end);
            master(1, 1'b0, t_end);
            master(1, 1'b1, t_end);
        join
        mon_en = 1'b0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
